// File: rtl/output_2qb_serializer.sv
// output_2qb_serializer: streams the psi_f amplitude table one byte per listener_flag rising edge, with even parity.
// Define OUTPUT_2QB_SERIALIZER_CHECKSUM_EN to append a modulo-256 checksum byte to every frame.
module output_2qb_serializer #(
    parameter int N           = 16,
    parameter int DEPTH       = 128,
    parameter int SYNC_STAGES = 2
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic [N*DEPTH-1:0] psi_f,
    input  logic               listener_flag,
    output logic [7:0]         out,
    output logic               parity
);
    localparam int BPW   = N / 8;
    localparam int BYTES = DEPTH * BPW;
`ifdef OUTPUT_2QB_SERIALIZER_CHECKSUM_EN
    localparam int FRAME = BYTES + 1;
`else
    localparam int FRAME = BYTES;
`endif
    localparam int IW = $clog2(FRAME + 1);
    localparam int OW = $clog2(N * DEPTH);

    logic [SYNC_STAGES-1:0] sync;
    logic                   edge_q;
    logic                   req;
    logic [IW-1:0]          idx;
    logic [N*DEPTH-1:0]     snap;
    logic [N*DEPTH-1:0]     src;
    logic [OW-1:0]          off;
    logic [7:0]             data;
    logic [7:0]             nxt;
    int                     ib;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync   <= '0;
            edge_q <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], listener_flag};
            edge_q <= sync[SYNC_STAGES-1];
        end
    end

    assign req = sync[SYNC_STAGES-1] & ~edge_q;

    // byte 0 reads live psi_f; the rest of the frame reads the snapshot taken with it
    always_comb begin
        ib   = int'(idx);
        src  = (idx == '0) ? psi_f : snap;
        off  = OW'((ib / BPW) * N + (BPW - 1 - ib % BPW) * 8);
        data = src[off +: 8];
    end

`ifdef OUTPUT_2QB_SERIALIZER_CHECKSUM_EN
    logic [7:0] sum;
    assign nxt = (idx == IW'(BYTES)) ? sum : data;
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            sum <= '0;
        else if (req)
            sum <= (idx == '0) ? data : sum + data;
    end
`else
    assign nxt = data;
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            out    <= '0;
            parity <= 1'b0;
            idx    <= '0;
            snap   <= '0;
        end else if (req) begin
            out    <= nxt;
            parity <= ^nxt;
            idx    <= (idx == IW'(FRAME - 1)) ? '0 : idx + 1'b1;
            if (idx == '0)
                snap <= psi_f;
        end
    end
endmodule

// File: tb/tb_output_2qb_serializer.sv
// tb_output_2qb_serializer: directed and randomized checks of the byte serializer against a table-level model.
module tb_output_2qb_serializer;
    localparam int N     = 16;
    localparam int DEPTH = 128;
    localparam int BPW   = N / 8;
    localparam int BYTES = DEPTH * BPW;
`ifdef OUTPUT_2QB_SERIALIZER_CHECKSUM_EN
    localparam int FRAME = BYTES + 1;
`else
    localparam int FRAME = BYTES;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               flag = 1'b0;
    logic [N*DEPTH-1:0] psi_f;
    logic [7:0]         out;
    logic               parity;

    logic [N-1:0] words  [DEPTH];
    logic [N-1:0] snap_m [DEPTH];
    int           j = 0;
    logic [7:0]   sum_m = '0;
    logic [7:0]   last_exp;
    int           checks = 0;
    int           failures = 0;

    output_2qb_serializer #(.N(N), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .i_clock(clk),
        .i_reset_n(rst_n),
        .psi_f(psi_f),
        .listener_flag(flag),
        .out(out),
        .parity(parity)
    );

    always #5 clk = ~clk;

    always_comb
        for (int k = 0; k < DEPTH; k++)
            psi_f[k*N +: N] = words[k];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // model: byte j is word j/BPW, most significant byte first; checksum closes the frame
    task automatic model_next(output logic [7:0] exp);
        logic [N-1:0] w;
        if (j == 0) begin
            for (int k = 0; k < DEPTH; k++) snap_m[k] = words[k];
            sum_m = '0;
        end
        if (j == BYTES) begin
            exp = sum_m;
        end else begin
            w     = snap_m[j / BPW];
            exp   = w[(BPW - 1 - j % BPW) * 8 +: 8];
            sum_m = sum_m + exp;
        end
        j = (j == FRAME - 1) ? 0 : j + 1;
    endtask

    task automatic request(input string tag);
        logic [7:0] prev, exp;
        @(negedge clk);
        prev = out;
        model_next(exp);
        flag = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 check({tag, "_latency_hold"}, out, prev);
        @(posedge clk);
        #1 check(tag, out, exp);
        check({tag, "_parity"}, {7'b0, parity}, {7'b0, ^exp});
        last_exp = exp;
        @(negedge clk);
        flag = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #2 check({tag, "_out"}, out, 8'h00);
        check({tag, "_parity"}, {7'b0, parity}, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        j = 0;
        sum_m = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] held;
        for (int k = 0; k < DEPTH; k++) words[k] = N'($urandom);
        // reset held with the request line toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            flag = ~flag;
            #1 check("rst_toggle_out", out, 8'h00);
            check("rst_toggle_parity", {7'b0, parity}, 8'h00);
        end
        @(negedge clk);
        flag = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_after_rst", out, 8'h00);
        check("idle_after_rst_parity", {7'b0, parity}, 8'h00);

        words[0] = 16'h0100;
        request("w0_0100");
        check("w0_0100_const", out, 8'h01);
        check("w0_0100_par_const", {7'b0, parity}, 8'h01);

        do_reset("rst_a");
        words[0] = 16'hA5C3;
        request("w0_hi");
        check("w0_hi_const", out, 8'hA5);
        request("w0_lo");
        check("w0_lo_const", out, 8'hC3);

        // a request held high for 20 cycles advances exactly once
        @(negedge clk);
        model_next(last_exp);
        flag = 1'b1;
        repeat (4) @(negedge clk);
        held = out;
        check("held_first", out, last_exp);
        repeat (16) @(negedge clk);
        check("held_stable", out, held);
        flag = 1'b0;
        repeat (3) @(negedge clk);
        request("after_held");

        // snapshot and wrap with word k = k*0x0101
        do_reset("rst_b");
        for (int k = 0; k < DEPTH; k++) words[k] = N'(k * 16'h0101);
        request("snap_b0");
        for (int k = 0; k < DEPTH; k++) words[k] = N'($urandom);
        for (int b = 1; b < BYTES; b++) begin
            if (b == 100) words[$urandom_range(DEPTH - 1)] = N'($urandom);
            request("frame_byte");
        end
        check("byte255_const", out, 8'h7F);
`ifdef OUTPUT_2QB_SERIALIZER_CHECKSUM_EN
        request("checksum_rand");
`endif
        request("new_frame_w0_hi");
        check("new_frame_w0_hi_direct", out, words[0][15:8]);

        // reset in the middle of a frame
        for (int b = 1; b < 37; b++) request("midframe");
        do_reset("rst_mid");
        request("after_rst_mid");
        check("after_rst_mid_direct", out, words[0][15:8]);

`ifdef OUTPUT_2QB_SERIALIZER_CHECKSUM_EN
        do_reset("rst_c");
        for (int k = 0; k < DEPTH; k++) words[k] = 16'h0001;
        for (int b = 0; b < FRAME; b++) request("cs_frame");
        check("checksum_const", out, 8'h80);
        check("checksum_par_const", {7'b0, parity}, 8'h01);
        request("cs_wrap");
        check("cs_wrap_const", out, 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/output_2qb_serializer.md
Name: output_2qb_serializer

Overview:
- Byte-serial readout stage for the 2-qubit VQE solver.
- Takes the full result table of final-state amplitudes (128 words of N bits) and streams it one byte at a time on an 8-bit port with a parity bit.
- Each new byte is paced by rising edges of an external receiver's listener_flag.
- Sits after the variational-circuit sweep, clocked by the divided shared clock.

Parameters:
- N, 16, amplitude word width in bits; must be a multiple of 8.
- DEPTH, 128, number of words in the psi_f table.
- SYNC_STAGES, 2, synchronizer flops on listener_flag; minimum 2.

Ports:
- i_clock  input  1  shared (divided) clock; all logic rises on posedge.
- i_reset_n  input  1  reset, asynchronous assert, active-low.
- psi_f  input  N*DEPTH  flattened amplitude table; word k occupies bits [k*N +: N].
- listener_flag  input  1  asynchronous byte-request strobe from the receiver.
- out  output  8  current byte.
- parity  output  1  even parity of out (XOR of out[7:0]).

Behaviour:
- Clock and reset: one clock (i_clock); reset is asynchronous and active-low (i_reset_n).
- Reset values: out=0, parity=0, byte index=0, all synchronizer flops=0, snapshot buffer=0.
- Frame: BYTES = DEPTH*N/8 bytes (256 by default).
  - Byte j is word j/(N/8), most-significant byte first.
  - Default sequence: w0[15:8], w0[7:0], w1[15:8], ...
- Request detection:
  - listener_flag passes through SYNC_STAGES flops, then an edge flop.
  - A request is the synchronized signal being 1 while the edge flop is 0.
- Latency: if listener_flag rises between edges e0 and e1, out and parity update on edge e(SYNC_STAGES+1), i.e. e3 by default.
- One byte per rising edge of listener_flag:
  - Holding listener_flag high produces no further bytes.
  - A low pulse shorter than one i_clock period may be missed; receivers hold each level for at least 2 periods.
- Snapshot:
  - When byte index 0 is issued, all of psi_f is captured into an internal buffer in the same cycle.
  - The byte 0 value itself comes from the live psi_f.
  - Bytes 1..BYTES-1 come from that buffer, so psi_f changes mid-frame do not appear until the next frame.
- out and parity are registered. Both change together and only on a request; otherwise they hold.
- Wrap-around: after byte BYTES-1, the index returns to 0. The next request starts a new frame with a fresh snapshot.
- Reset mid-frame: out and parity clear immediately, the index returns to 0, and the next request sends w0 high byte.
- Reset coinciding with a request edge: reset wins.

Optional Feature:
- Macro: OUTPUT_2QB_SERIALIZER_CHECKSUM_EN.
- Defined:
  - The frame is BYTES+1 long.
  - The extra final byte is the modulo-256 sum of the BYTES data bytes sent in that frame, with parity computed normally.
  - Wrap to index 0 occurs after the checksum byte.
- Undefined: no checksum byte; the frame is exactly BYTES long.

Test Plan:
- Reset: assert i_reset_n=0 with listener_flag toggling -> out=0x00, parity=0 throughout; release, no request -> outputs hold 0.
- First two requests with psi_f w0=0xA5C3: first rising edge -> out=0xA5, parity=0, exactly 3 i_clock edges after the flag rises; second edge -> out=0xC3, parity=0. With w0=0x0100 -> out=0x01, parity=1.
- Held request: listener_flag high for 20 cycles -> exactly one byte advance, and out is stable afterwards.
- Snapshot and wrap, with psi_f word k = k*0x0101:
  - Change psi_f after byte 0 -> bytes 1..255 still follow the original pattern (byte 255 = 0x7F).
  - Request 257 -> a new frame with the new psi_f high byte of w0.
- Reset mid-frame: after 37 bytes, pulse i_reset_n low -> out=0; next request -> w0 high byte.
- Checksum (macro defined), all words 0x0001: byte 256 = 0x80, parity=1; next request -> 0x00 (w0 high byte).
